// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one word read per
// cycle into a registered-read instruction memory, buffers returned words
// with their PC in a small prefetch queue, and presents the queue head to
// decode over valid/ready. A redirect flushes everything and refetches.
module imem_fetch_ctrl #(
  parameter int unsigned          ADDR_W   = 30,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          QDEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_en,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [31:0]               mem_rdata,
  input  logic                      redirect_valid,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instr,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam logic [PW+1:0] DEPTH = (PW+2)'(QDEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [31:0]       q_instr [QDEPTH];
  logic [ADDR_W-1:0] q_pc    [QDEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count;
  logic [PW+1:0]     occupancy;
  logic              space, enq, deq;

  // Run/idle state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, issue decision and queue enqueue/dequeue strobes
  always_comb begin
    state_n   = state;
    occupancy = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
    space     = 1'b0;
    mem_req   = 1'b0;
    enq       = 1'b0;
    deq       = 1'b0;
    case (state)
      IDLE: if (fetch_en)  state_n = RUN;
      RUN:  if (!fetch_en) state_n = IDLE;
      default:             state_n = IDLE;
    endcase
    // A slot freed by a same-cycle handshake may be reused by a new read,
    // which is what sustains one instruction per cycle at full occupancy.
    space   = (occupancy < DEPTH) ||
              ((occupancy == DEPTH) && out_valid && out_ready);
    mem_req = (state == RUN) && fetch_en && !redirect_valid && space;
    // A response returning in a redirect cycle belongs to the old path.
    enq     = inflight && !redirect_valid;
    deq     = out_valid && out_ready && !redirect_valid;
  end

  assign mem_addr  = fetch_pc;
  assign out_valid = (count != '0);
  assign out_instr = q_instr[rd_ptr];
  assign out_pc    = q_pc[rd_ptr];
  assign q_count   = count;

  // Fetch PC and in-flight read tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      inflight <= mem_req;
      if (mem_req) inflight_pc <= fetch_pc;
      if (redirect_valid)
        fetch_pc <= redirect_pc & ~ADDR_W'(3);
      else if (mem_req)
        fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  // Prefetch queue storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        q_instr[wr_ptr] <= mem_rdata;
        q_pc[wr_ptr]    <= inflight_pc;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: streaming, back-pressure, redirect,
// misaligned redirect, fetch disable, mid-cycle reset and PC wrap.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_en, out_ready, redirect_valid;
  logic [29:0] redirect_pc;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [29:0] out_pc;
  logic [1:0]  q_count;

  logic        fetch_en_b;
  logic        mem_req_b;
  logic [29:0] mem_addr_b;
  logic [31:0] mem_rdata_b;
  logic        out_valid_b;
  logic [31:0] out_instr_b;
  logic [29:0] out_pc_b;
  logic [1:0]  q_count_b;

  int errors = 0;
  int checks = 0;

  imem_fetch_ctrl #(.ADDR_W(30), .RESET_PC(30'h0), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .q_count(q_count)
  );

  imem_fetch_ctrl #(.ADDR_W(30), .RESET_PC(30'h3FFFFFFC), .QDEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en_b),
    .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
    .redirect_valid(1'b0), .redirect_pc(30'h0),
    .out_valid(out_valid_b), .out_ready(1'b1),
    .out_instr(out_instr_b), .out_pc(out_pc_b), .q_count(q_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] code(input logic [29:0] a);
    if (a == 30'h0) return 32'h00430820;
    return 32'hC0DE0000 ^ {2'b00, a};
  endfunction

  // Registered-read instruction memory models
  always @(posedge clk) begin
    mem_rdata   <= code(mem_addr);
    mem_rdata_b <= code(mem_addr_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; fetch_en_b = 1'b0;
    #12;
    check("rst_mem_req",   32'(mem_req),   0);
    check("rst_mem_addr",  32'(mem_addr),  0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_instr", out_instr,      0);
    check("rst_out_pc",    32'(out_pc),    0);
    check("rst_q_count",   32'(q_count),   0);
    check("rst_wrap_addr", 32'(mem_addr_b), 32'h3FFFFFFC);

    // E0: release reset, start fetching with decode ready
    step(); rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1; #1;
    check("idle_no_req", 32'(mem_req), 0);
    step(); // E1: RUN
    check("first_req",  32'(mem_req),  1);
    check("first_addr", 32'(mem_addr), 0);
    step(); // E2
    check("e2_valid", 32'(out_valid), 0);
    check("e2_addr",  32'(mem_addr),  4);
    step(); // E3
    check("e3_valid", 32'(out_valid), 1);
    check("e3_pc",    32'(out_pc),    0);
    check("e3_instr", out_instr,      32'h00430820);
    check("e3_req",   32'(mem_req),   1);
    step(); // E4
    check("e4_pc",    32'(out_pc), 4);
    check("e4_instr", out_instr,   code(30'd4));
    step(); // E5: stall decode
    check("e5_pc", 32'(out_pc), 8);
    out_ready = 1'b0; #1;
    check("stall_req", 32'(mem_req), 0);
    step(); // E6
    check("full_count", 32'(q_count), 2);
    check("full_req",   32'(mem_req), 0);
    check("full_pc",    32'(out_pc),  8);
    step(); // E7
    check("hold_pc",    32'(out_pc), 8);
    check("hold_instr", out_instr,   code(30'd8));
    out_ready = 1'b1; #1;
    check("release_req",  32'(mem_req),  1);
    check("release_addr", 32'(mem_addr), 16);
    step(); check("e8_pc",  32'(out_pc), 12);
    step(); check("e9_pc",  32'(out_pc), 16);
    step(); check("e10_pc", 32'(out_pc), 20);
    step(); // E11: head 24, read of 28 in flight
    check("e11_pc",    32'(out_pc),  24);
    check("e11_count", 32'(q_count), 1);
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 30'h100; #1;
    check("redir_no_req", 32'(mem_req), 0);
    step(); // E12
    redirect_valid = 1'b0; out_ready = 1'b1; #1;
    check("redir_flush_valid", 32'(out_valid), 0);
    check("redir_flush_count", 32'(q_count),   0);
    check("redir_req",         32'(mem_req),   1);
    check("redir_addr",        32'(mem_addr),  32'h100);
    step(); check("redir_e13_valid", 32'(out_valid), 0);
    step(); // E14
    check("redir_out_valid", 32'(out_valid), 1);
    check("redir_out_pc",    32'(out_pc),    32'h100);
    check("redir_out_instr", out_instr,      code(30'h100));
    redirect_valid = 1'b1; redirect_pc = 30'h103; #1;
    step(); // E15
    redirect_valid = 1'b0; #1;
    check("misalign_addr",  32'(mem_addr),  32'h100);
    check("misalign_valid", 32'(out_valid), 0);
    step(); check("misalign_e16_valid", 32'(out_valid), 0);
    step(); // E17
    check("misalign_out_pc", 32'(out_pc), 32'h100);
    fetch_en = 1'b0; out_ready = 1'b0; #1;
    check("disable_req", 32'(mem_req), 0);
    step(); // E18: in-flight 0x104 still lands
    check("drain_count", 32'(q_count),  2);
    check("drain_head",  32'(out_pc),   32'h100);
    check("drain_addr",  32'(mem_addr), 32'h108);
    out_ready = 1'b1; #1;
    step(); // E19
    check("drain_pc2",    32'(out_pc),  32'h104);
    check("drain_count1", 32'(q_count), 1);
    check("drain_req",    32'(mem_req), 0);
    step(); // E20
    check("drained_valid", 32'(out_valid), 0);
    check("held_addr",     32'(mem_addr),  32'h108);
    redirect_valid = 1'b1; redirect_pc = 30'h200; #1;
    step(); // E21
    redirect_valid = 1'b0; #1;
    check("idle_redir_addr", 32'(mem_addr), 32'h200);
    check("idle_redir_req",  32'(mem_req),  0);
    fetch_en = 1'b1; #1;
    step(); check("resume_addr", 32'(mem_addr), 32'h200);
    step();
    step(); // E24
    check("resume_pc", 32'(out_pc), 32'h200);
    rst_n = 1'b0; #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_count", 32'(q_count),   0);
    check("midrst_addr",  32'(mem_addr),  0);
    check("midrst_pc",    32'(out_pc),    0);
    rst_n = 1'b1; #1;
    step(); // E25: pending response discarded
    check("restart_valid", 32'(out_valid), 0);
    check("restart_req",   32'(mem_req),   1);
    check("restart_addr",  32'(mem_addr),  0);
    step();
    step(); // E27
    check("restart_pc",    32'(out_pc), 0);
    check("restart_instr", out_instr,   32'h00430820);

    // PC wrap on the second instance
    fetch_en = 1'b0;
    fetch_en_b = 1'b1; #1;
    step(); check("wrap_addr0", 32'(mem_addr_b), 32'h3FFFFFFC);
    check("wrap_req", 32'(mem_req_b), 1);
    step(); check("wrap_addr1", 32'(mem_addr_b), 0);
    step(); check("wrap_pc0", 32'(out_pc_b), 32'h3FFFFFFC);
    check("wrap_instr0", out_instr_b, code(30'h3FFFFFFC));
    step(); check("wrap_pc1", 32'(out_pc_b), 0);
    check("wrap_instr1", out_instr_b, 32'h00430820);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
